// File: rtl/cell_painter.sv
// Pixel-stream generator for the Connect-Four VGA path: rasters one token, pointer,
// erased cell or the full board background as (x, y, colour, plot) beats, one per clock.
module cell_painter #(
    parameter int unsigned BLOCK_LEN    = 4,
    parameter int unsigned GAP_LEN      = 2,
    parameter int unsigned COLS         = 7,
    parameter int unsigned ROWS         = 6,
    parameter int unsigned COL_W        = 3,
    parameter int unsigned ROW_W        = 3,
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 7,
    parameter int unsigned BOARD_X0     = 0,
    parameter int unsigned BOARD_Y0     = 8,
    parameter int unsigned POINTER_Y    = 0,
    parameter logic [2:0]  BG_COLOUR    = 3'b001,
    parameter logic [2:0]  EMPTY_COLOUR = 3'b000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic             player,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [2:0]       colour,
    output logic             plot
);

    localparam int unsigned PITCH   = BLOCK_LEN + GAP_LEN;
    localparam int unsigned BOARD_W = COLS * PITCH + GAP_LEN;
    localparam int unsigned BOARD_H = ROWS * PITCH + GAP_LEN;
    localparam int unsigned MAX_W   = (BOARD_W > BLOCK_LEN) ? BOARD_W : BLOCK_LEN;
    localparam int unsigned MAX_H   = (BOARD_H > BLOCK_LEN) ? BOARD_H : BLOCK_LEN;
    localparam int unsigned DX_W    = $clog2(MAX_W + 1);
    localparam int unsigned DY_W    = $clog2(MAX_H + 1);

    localparam logic [1:0] ModeToken   = 2'b00;
    localparam logic [1:0] ModePointer = 2'b01;
    localparam logic [1:0] ModeErase   = 2'b10;
    localparam logic [1:0] ModeClear   = 2'b11;

    typedef enum logic [1:0] {StIdle, StDraw, StFinish} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             player_q, player_d;
    logic             err_q, err_d;
    logic [DX_W-1:0]  dx_q, dx_d, last_dx;
    logic [DY_W-1:0]  dy_q, dy_d, last_dy;
    logic [X_W-1:0]   x_q, pix_x;
    logic [Y_W-1:0]   y_q, pix_y;
    logic [2:0]       colour_q, pix_colour;
    logic             req_valid;

    always_comb begin
        req_valid = 1'b1;
        unique case (mode)
            ModeClear:   req_valid = 1'b1;
            ModePointer: req_valid = (32'(col) < COLS);
            default:     req_valid = (32'(col) < COLS) && (32'(row) < ROWS);
        endcase
    end

    always_comb begin
        if (mode_q == ModeClear) begin
            last_dx = DX_W'(BOARD_W - 1);
            last_dy = DY_W'(BOARD_H - 1);
        end else begin
            last_dx = DX_W'(BLOCK_LEN - 1);
            last_dy = DY_W'(BLOCK_LEN - 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        col_d    = col_q;
        row_d    = row_q;
        player_d = player_q;
        err_d    = err_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = mode;
                    col_d    = col;
                    row_d    = row;
                    player_d = player;
                    dx_d     = '0;
                    dy_d     = '0;
                    err_d    = !req_valid;
                    state_d  = req_valid ? StDraw : StFinish;
                end
            end
            StDraw: begin
                if (dx_q == last_dx) begin
                    dx_d = '0;
                    if (dy_q == last_dy) begin
                        state_d = StFinish;
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pixel for the cycle after this edge, so the first beat appears right after acceptance.
    always_comb begin
        pix_x      = X_W'(BOARD_X0 + GAP_LEN + 32'(col_d) * PITCH + 32'(dx_d));
        pix_y      = Y_W'(BOARD_Y0 + GAP_LEN + (ROWS - 1 - 32'(row_d)) * PITCH + 32'(dy_d));
        pix_colour = player_d ? 3'b110 : 3'b100;
        unique case (mode_d)
            ModeToken: begin
            end
            ModePointer: begin
                pix_y = Y_W'(POINTER_Y + GAP_LEN + 32'(dy_d));
            end
            ModeErase: begin
                pix_colour = EMPTY_COLOUR;
            end
            ModeClear: begin
                pix_x      = X_W'(BOARD_X0 + 32'(dx_d));
                pix_y      = Y_W'(BOARD_Y0 + 32'(dy_d));
                pix_colour = BG_COLOUR;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            player_q <= 1'b0;
            err_q    <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            col_q    <= col_d;
            row_q    <= row_d;
            player_q <= player_d;
            err_q    <= err_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            // Outputs hold their last drawn value whenever no pixel is being plotted.
            if (state_d == StDraw) begin
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_colour;
            end
        end
    end

    assign plot   = (state_q == StDraw);
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StFinish);
    assign err    = done & err_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_cell_painter.sv
// Randomised bench for cell_painter: each request is expanded into its expected pixel list
// by a geometric model and compared beat by beat with the DUT output stream.
module tb_cell_painter;

    localparam int BL    = 4;
    localparam int GAP   = 2;
    localparam int NCOLS = 7;
    localparam int NROWS = 6;
    localparam int X0    = 0;
    localparam int Y0    = 8;
    localparam int PY    = 0;
    localparam int BW    = NCOLS * (BL + GAP) + GAP;
    localparam int BH    = NROWS * (BL + GAP) + GAP;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pixel_t;

    pixel_t exp_q[$];
    bit     exp_valid;
    int     last_x, last_y, last_c;

    cell_painter dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .mode   (mode),
        .col    (col),
        .row    (row),
        .player (player),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (time %0t)", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] observed();
        return {10'b0, plot, busy, done, err, x, y, colour};
    endfunction

    function automatic logic [31:0] pack(input bit p, input bit b, input bit d, input bit e,
                                         input int px, input int py, input int pc);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = px[7:0];
        yy = py[6:0];
        cc = pc[2:0];
        return {10'b0, p, b, d, e, xx, yy, cc};
    endfunction

    // Expected pixel list for one request, straight from the board geometry.
    task automatic build_exp(input int m, input int c, input int r, input int p);
        pixel_t pix;
        int w, h;
        exp_q.delete();
        exp_valid = (m == 3) || ((c < NCOLS) && ((m == 1) || (r < NROWS)));
        if (!exp_valid) return;
        w = (m == 3) ? BW : BL;
        h = (m == 3) ? BH : BL;
        for (int dy = 0; dy < h; dy++) begin
            for (int dx = 0; dx < w; dx++) begin
                case (m)
                    3: begin
                        pix.px = X0 + dx;
                        pix.py = Y0 + dy;
                        pix.pc = 1;
                    end
                    1: begin
                        pix.px = X0 + GAP + c * (BL + GAP) + dx;
                        pix.py = PY + GAP + dy;
                        pix.pc = p ? 6 : 4;
                    end
                    default: begin
                        pix.px = X0 + GAP + c * (BL + GAP) + dx;
                        pix.py = Y0 + GAP + (NROWS - 1 - r) * (BL + GAP) + dy;
                        pix.pc = (m == 2) ? 0 : (p ? 6 : 4);
                    end
                endcase
                exp_q.push_back(pix);
            end
        end
    endtask

    // Leaves the bench at the negedge of the first cycle after the accepting edge.
    task automatic drive_start(input int m, input int c, input int r, input int p,
                               input bit hold);
        @(negedge clk);
        start  = 1'b1;
        mode   = 2'(m);
        col    = 3'(c);
        row    = 3'(r);
        player = 1'(p);
        @(negedge clk);
        start = hold;
    endtask

    task automatic check_draw(input int m, input int c, input int r, input int p,
                              input bit scramble, input bit hold);
        build_exp(m, c, r, p);
        foreach (exp_q[i]) begin
            check("pixel", observed(), pack(1, 1, 0, 0, exp_q[i].px, exp_q[i].py, exp_q[i].pc));
            last_x = exp_q[i].px;
            last_y = exp_q[i].py;
            last_c = exp_q[i].pc;
            if (scramble) begin
                start  = 1'($urandom_range(0, 1));
                mode   = 2'($urandom);
                col    = 3'($urandom);
                row    = 3'($urandom);
                player = 1'($urandom);
            end
            @(negedge clk);
        end
        check("finish", observed(), pack(0, 1, 1, !exp_valid, last_x, last_y, last_c));
        start = hold;
        @(negedge clk);
        check("idle", observed(), pack(0, 0, 0, 0, last_x, last_y, last_c));
    endtask

    initial begin
        int m, c, r, p;
        resetn = 1'b0;
        start  = 1'b0;
        mode   = '0;
        col    = '0;
        row    = '0;
        player = 1'b0;
        last_x = 0;
        last_y = 0;
        last_c = 0;
        repeat (3) @(negedge clk);
        check("reset", observed(), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_idle", observed(), 32'd0);

        drive_start(0, 3, 0, 1, 0);
        check_draw(0, 3, 0, 1, 0, 0);
        drive_start(1, 0, 5, 0, 0);
        check_draw(1, 0, 5, 0, 0, 0);
        drive_start(3, 2, 7, 0, 0);
        check_draw(3, 2, 7, 0, 0, 0);
        drive_start(0, 7, 0, 0, 0);
        check_draw(0, 7, 0, 0, 0, 0);
        drive_start(2, 1, 6, 0, 0);
        check_draw(2, 1, 6, 0, 0, 0);
        drive_start(0, 4, 2, 0, 0);
        check_draw(0, 4, 2, 0, 1, 0);

        // Reset in the middle of a token draw aborts it at once.
        drive_start(0, 2, 3, 0, 0);
        build_exp(0, 2, 3, 0);
        for (int i = 0; i < 5; i++) begin
            check("pre_reset", observed(),
                  pack(1, 1, 0, 0, exp_q[i].px, exp_q[i].py, exp_q[i].pc));
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        check("reset_abort", observed(), 32'd0);
        last_x = 0;
        last_y = 0;
        last_c = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_abort_idle", observed(), 32'd0);
        drive_start(0, 5, 4, 1, 0);
        check_draw(0, 5, 4, 1, 0, 0);

        // Start held high: back-to-back draws with one idle cycle between them.
        drive_start(2, 6, 5, 0, 1);
        check_draw(2, 6, 5, 0, 0, 1);
        @(negedge clk);
        check_draw(2, 6, 5, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            m = $urandom_range(0, 3);
            if (m == 3 && $urandom_range(0, 3) != 0) m = 0;
            c = $urandom_range(0, 7);
            r = $urandom_range(0, 7);
            p = $urandom_range(0, 1);
            drive_start(m, c, r, p, 0);
            check_draw(m, c, r, p, k[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
